// File: rtl/segasys1_sndcmd_ctrl.sv
// Sound-command scheduler: queues main-CPU command bytes and raises one sound-CPU NMI per command.
// Define SEGASYS1_SNDQ_FIFO_EN for the 2^DEPTH_LOG2 queue; otherwise a single-entry latch (newest wins).
module segasys1_sndcmd_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned NMI_GAP    = 64
) (
    input  logic                  CLK48M,
    input  logic                  RESET,
    input  logic                  SNDRQ,
    input  logic [7:0]            SNDNO,
    input  logic                  SRD,
    output logic [7:0]            SNDDO,
    output logic                  SNMI,
    output logic                  SFULL,
    output logic [DEPTH_LOG2:0]   SCOUNT,
    output logic                  SOVF
);

    localparam int unsigned CW = DEPTH_LOG2 + 1;
    localparam int unsigned GW = $clog2(NMI_GAP + 1);
`ifdef SEGASYS1_SNDQ_FIFO_EN
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
`else
    localparam int unsigned DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_NMI,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            snmi_q, snmi_d;
    logic            rq_prev_q, rq_prev_d;
    logic            rd_prev_q, rd_prev_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop, full;

    // Strobe edge detection; previous levels reset high so a held strobe is not an edge.
    always_comb begin
        rq_prev_d = SNDRQ;
        rd_prev_d = SRD;
        full      = (count_q == CW'(DEPTH));
        push      = SNDRQ & ~rq_prev_q;
        pop       = SRD & ~rd_prev_q & (count_q != '0);
    end

`ifdef SEGASYS1_SNDQ_FIFO_EN
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [PW-1:0]   wp_q, wp_d;
    logic [PW-1:0]   rp_q, rp_d;
    logic            ovf_q, ovf_d;
    logic            accept;

    // A push into a full queue is still accepted when a pop frees a slot on the same edge.
    always_comb begin
        mem_d  = mem_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        ovf_d  = ovf_q;
        accept = push & (~full | pop);
        if (accept) begin
            mem_d[wp_q] = SNDNO;
            wp_d        = wp_q + PW'(1);
        end
        if (pop) begin
            rp_d = rp_q + PW'(1);
        end
        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end
        count_d = count_q + CW'(accept) - CW'(pop);
    end

    always_ff @(posedge CLK48M) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            wp_q  <= '0;
            rp_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            ovf_q <= ovf_d;
        end
    end

    assign SNDDO = (count_q == '0) ? 8'hFF : mem_q[rp_q];
    assign SOVF  = ovf_q;
`else
    logic [7:0]      latch_q, latch_d;

    always_comb begin
        latch_d = push ? SNDNO : latch_q;
        count_d = count_q;
        if (push) begin
            count_d = CW'(1);
        end else if (pop) begin
            count_d = '0;
        end
    end

    always_ff @(posedge CLK48M) begin
        latch_q <= latch_d;
    end

    assign SNDDO = (count_q == '0) ? 8'hFF : latch_q;
    assign SOVF  = 1'b0;
`endif

    // NMI sequencer: only a pop seen while NMI is asserted starts the gap.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_NMI;
                end
            end
            S_NMI: begin
                if (pop) begin
                    state_d = S_GAP;
                    gap_d   = GW'(NMI_GAP - 1);
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        snmi_d = (state_d == S_NMI);
    end

    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            gap_q     <= '0;
            snmi_q    <= 1'b0;
            rq_prev_q <= 1'b1;
            rd_prev_q <= 1'b1;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            snmi_q    <= snmi_d;
            rq_prev_q <= rq_prev_d;
            rd_prev_q <= rd_prev_d;
            count_q   <= count_d;
        end
    end

    assign SNMI   = snmi_q;
    assign SFULL  = full;
    assign SCOUNT = count_q;

endmodule

// File: tb/tb_segasys1_sndcmd_ctrl.sv
// Self-checking bench for segasys1_sndcmd_ctrl: directed plan plus randomized strobes against a queue-based model.
// Follows the SEGASYS1_SNDQ_FIFO_EN build selection of the design.
module tb_segasys1_sndcmd_ctrl;

    localparam int unsigned DEPTH_LOG2 = 2;
    localparam int unsigned NMI_GAP    = 64;
`ifdef SEGASYS1_SNDQ_FIFO_EN
    localparam int MDEPTH = 1 << DEPTH_LOG2;
`else
    localparam int MDEPTH = 1;
`endif

    logic                clk = 1'b0;
    logic                RESET;
    logic                SNDRQ;
    logic [7:0]          SNDNO;
    logic                SRD;
    logic [7:0]          SNDDO;
    logic                SNMI;
    logic                SFULL;
    logic [DEPTH_LOG2:0] SCOUNT;
    logic                SOVF;

    segasys1_sndcmd_ctrl #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .NMI_GAP   (NMI_GAP)
    ) dut (
        .CLK48M(clk),
        .RESET (RESET),
        .SNDRQ (SNDRQ),
        .SNDNO (SNDNO),
        .SRD   (SRD),
        .SNDDO (SNDDO),
        .SNMI  (SNMI),
        .SFULL (SFULL),
        .SCOUNT(SCOUNT),
        .SOVF  (SOVF)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte queue, strobe history, NMI flag and earliest edge a new NMI may rise.
    logic [7:0] mq[$];
    bit         m_nmi  = 0;
    bit         m_ovf  = 0;
    bit         m_prq  = 1;
    bit         m_prd  = 1;
    int         m_ready = 0;

    always @(posedge clk) begin
        bit mpush, mpop;
        int cnt_before;
        cyc++;
        if (RESET) begin
            mq.delete();
            m_ovf   = 0;
            m_nmi   = 0;
            m_prq   = 1;
            m_prd   = 1;
            m_ready = cyc + 1;
        end else begin
            cnt_before = mq.size();
            mpush = SNDRQ && !m_prq;
            mpop  = SRD && !m_prd && (cnt_before != 0);
            if (m_nmi) begin
                if (mpop) begin
                    m_nmi   = 0;
                    m_ready = cyc + NMI_GAP + 1;
                end
            end else if (cyc >= m_ready && cnt_before != 0) begin
                m_nmi = 1;
            end
            if (mpop) void'(mq.pop_front());
            if (mpush) begin
                if (MDEPTH == 1) begin
                    mq.delete();
                    mq.push_back(SNDNO);
                end else if (cnt_before < MDEPTH || mpop) begin
                    mq.push_back(SNDNO);
                end else begin
                    m_ovf = 1;
                end
            end
            m_prq = SNDRQ;
            m_prd = SRD;
        end
        #2;
        chk("model_snddo", SNDDO, (mq.size() != 0) ? mq[0] : 8'hFF);
        chk("model_snmi", SNMI, m_nmi);
        chk("model_scount", SCOUNT, mq.size());
        chk("model_sfull", SFULL, mq.size() == MDEPTH);
        chk("model_sovf", SOVF, m_ovf);
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push_b(input logic [7:0] b);
        SNDNO = b;
        SNDRQ = 1'b1;
        tick();
        SNDRQ = 1'b0;
        tick();
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk(name, SNDDO, exp);
        SRD = 1'b1;
        tick();
        SRD = 1'b0;
        tick();
    endtask

    task automatic wait_nmi(output bit ok);
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            if (SNMI) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) chk("nmi_timeout", 0, 1);
    endtask

    initial begin
        logic [7:0] exp_b[$];
        int r, jprev;
        bit ok;
        RESET = 1'b1;
        SNDRQ = 1'b1;
        SRD   = 1'b1;
        SNDNO = 8'h00;
        repeat (3) tick();
        RESET = 1'b0;
        repeat (3) tick();
        chk("rst_scount", SCOUNT, 0);
        chk("rst_snmi", SNMI, 0);
        chk("rst_snddo", SNDDO, 8'hFF);
        chk("rst_sfull", SFULL, 0);
        chk("rst_sovf", SOVF, 0);
        SNDRQ = 1'b0;
        SRD   = 1'b0;
        repeat (2) tick();

        // single command
        SNDNO = 8'h81;
        SNDRQ = 1'b1;
        tick();
        chk("single_scount", SCOUNT, 1);
        chk("single_snddo", SNDDO, 8'h81);
        chk("single_snmi_early", SNMI, 0);
        tick();
        chk("single_snmi", SNMI, 1);
        repeat (5) tick();
        SNDRQ = 1'b0;
        repeat (20) tick();
        chk("held_rq_once", SCOUNT, 1);
        SRD = 1'b1;
        tick();
        chk("pop_snmi", SNMI, 0);
        chk("pop_snddo", SNDDO, 8'hFF);
        chk("pop_scount", SCOUNT, 0);
        repeat (5) tick();
        SRD = 1'b0;
        repeat (80) tick();
        chk("idle_snmi", SNMI, 0);

        // burst of three
`ifdef SEGASYS1_SNDQ_FIFO_EN
        exp_b = '{8'h01, 8'h02, 8'h03};
`else
        exp_b = '{8'h03};
`endif
        push_b(8'h01);
        push_b(8'h02);
        push_b(8'h03);
        jprev = 0;
        for (int i = 0; i < exp_b.size(); i++) begin
            wait_nmi(ok);
            r = cyc;
            if (ok && i > 0) chk("nmi_gap", r - jprev, NMI_GAP + 1);
            repeat (4) tick();
            chk("burst_byte", SNDDO, exp_b[i]);
            SRD = 1'b1;
            tick();
            jprev = cyc;
            chk("burst_snmi_low", SNMI, 0);
            SRD = 1'b0;
            tick();
        end
        repeat (100) tick();
        chk("burst_no_extra_nmi", SNMI, 0);
        chk("burst_empty", SCOUNT, 0);

        // overflow
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
        for (int b = 8'h10; b <= 8'h14; b++) push_b(8'(b));
`ifdef SEGASYS1_SNDQ_FIFO_EN
        chk("ovf_sfull", SFULL, 1);
        chk("ovf_scount", SCOUNT, 4);
        chk("ovf_sovf", SOVF, 1);
        for (int i = 0; i < 4; i++) pop_chk("ovf_pop", 8'(8'h10 + i));
        chk("ovf_drained", SCOUNT, 0);
        chk("ovf_sticky", SOVF, 1);
`else
        chk("latch_snddo", SNDDO, 8'h14);
        chk("latch_scount", SCOUNT, 1);
        chk("latch_sovf", SOVF, 0);
        chk("latch_sfull", SFULL, 1);
`endif

        // simultaneous push/pop on a full queue, or overwrite in the latch build
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
`ifdef SEGASYS1_SNDQ_FIFO_EN
        for (int b = 8'h20; b <= 8'h23; b++) push_b(8'(b));
        SNDNO = 8'h24;
        SNDRQ = 1'b1;
        SRD   = 1'b1;
        tick();
        chk("pp_scount", SCOUNT, 4);
        chk("pp_sovf", SOVF, 0);
        chk("pp_snddo", SNDDO, 8'h21);
        SNDRQ = 1'b0;
        SRD   = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) pop_chk("pp_pop", 8'(8'h21 + i));
`else
        push_b(8'hA0);
        push_b(8'hA1);
        chk("ow_snddo", SNDDO, 8'hA1);
        chk("ow_scount", SCOUNT, 1);
        chk("ow_sovf", SOVF, 0);
`endif

        // randomized strobes, occasional reset
        for (int n = 0; n < 4000; n++) begin
            RESET = ($urandom_range(0, 299) == 0);
            SNDRQ = ($urandom_range(0, 3) == 0);
            SRD   = ($urandom_range(0, 4) == 0);
            SNDNO = 8'($urandom);
            tick();
        end
        RESET = 1'b0;
        SNDRQ = 1'b0;
        SRD   = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
